// File: rtl/vga_scaler_ctrl.sv
// VGA timing generator with scaled texel addressing for an external pixel RAM.
// Sync, enable and strobe signals are delayed so that they stay aligned with
// the RAM data for any read latency.
module vga_scaler_ctrl #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned SCALE_LOG2 = 3,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned COLOR_W    = 4,
    parameter logic        HS_POL     = 1'b0,
    parameter logic        VS_POL     = 1'b0,
    localparam int unsigned CW_RAW    = $clog2(H_ACTIVE >> SCALE_LOG2),
    localparam int unsigned RW_RAW    = $clog2(V_ACTIVE >> SCALE_LOG2),
    localparam int unsigned CW        = (CW_RAW == 0) ? 1 : CW_RAW,
    localparam int unsigned RW        = (RW_RAW == 0) ? 1 : RW_RAW
) (
    input  logic                   vga_clk,
    input  logic                   clrn,
    input  logic [3*COLOR_W-1:0]   din,
    output logic [CW-1:0]          col_addr,
    output logic [RW-1:0]          row_addr,
    output logic                   rd_en,
    output logic                   hs,
    output logic                   vs,
    output logic                   de,
    output logic [COLOR_W-1:0]     r,
    output logic [COLOR_W-1:0]     g,
    output logic [COLOR_W-1:0]     b,
    output logic                   frame_start,
    output logic                   line_start
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int unsigned HA0     = H_SYNC + H_BP;
    localparam int unsigned HA1     = HA0 + H_ACTIVE;
    localparam int unsigned VA0     = V_SYNC + V_BP;
    localparam int unsigned VA1     = VA0 + V_ACTIVE;
    localparam int unsigned HCW     = $clog2(H_TOTAL);
    localparam int unsigned VCW     = $clog2(V_TOTAL);
    // Side-band delay stages before the output register.
    localparam int unsigned DL      = RD_LAT + 1;
    localparam int unsigned SW      = 5;

    // Side-band bit positions: hs_idle, vs_idle, act, frame first pixel, line first pixel.
    localparam int unsigned S_HS = 0;
    localparam int unsigned S_VS = 1;
    localparam int unsigned S_AC = 2;
    localparam int unsigned S_FS = 3;
    localparam int unsigned S_LS = 4;

    logic [HCW-1:0]          h_cnt_q, h_cnt_d;
    logic [VCW-1:0]          v_cnt_q, v_cnt_d;
    logic                    h_act, v_act, act;
    logic [SW-1:0]           side_raw;
    logic [CW-1:0]           col_addr_q, col_addr_d;
    logic [RW-1:0]           row_addr_q, row_addr_d;
    logic                    rd_en_q, rd_en_d;
    logic [DL-1:0][SW-1:0]   side_dly_q, side_dly_d;
    logic [SW-1:0]           tap;
    logic [COLOR_W-1:0]      r_q, r_d, g_q, g_d, b_q, b_d;
    logic                    hs_q, hs_d, vs_q, vs_d, de_q, de_d;
    logic                    fs_q, fs_d, ls_q, ls_d;

    // Horizontal/vertical counters; vertical advances on the horizontal wrap.
    always_comb begin
        h_cnt_d = h_cnt_q + HCW'(1);
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == HCW'(H_TOTAL - 1)) begin
            h_cnt_d = '0;
            if (v_cnt_q == VCW'(V_TOTAL - 1)) begin
                v_cnt_d = '0;
            end else begin
                v_cnt_d = v_cnt_q + VCW'(1);
            end
        end
    end

    // Raw timing decode; sync flags are stored as "idle" so an all-zero delay line means sync-active.
    always_comb begin
        h_act            = (32'(h_cnt_q) >= HA0) && (32'(h_cnt_q) < HA1);
        v_act            = (32'(v_cnt_q) >= VA0) && (32'(v_cnt_q) < VA1);
        act              = h_act && v_act;
        side_raw         = '0;
        side_raw[S_HS]   = 32'(h_cnt_q) >= H_SYNC;
        side_raw[S_VS]   = 32'(v_cnt_q) >= V_SYNC;
        side_raw[S_AC]   = act;
        side_raw[S_FS]   = (32'(h_cnt_q) == HA0) && (32'(v_cnt_q) == VA0);
        side_raw[S_LS]   = (32'(h_cnt_q) == HA0) && v_act;
    end

    // Texel address stage: subtract at counter width, then shift and truncate.
    always_comb begin
        col_addr_d = '0;
        row_addr_d = '0;
        rd_en_d    = act;
        if (act) begin
            col_addr_d = CW'((h_cnt_q - HCW'(HA0)) >> SCALE_LOG2);
            row_addr_d = RW'((v_cnt_q - VCW'(VA0)) >> SCALE_LOG2);
        end
    end

    // Side-band delay line matching the address stage plus RAM latency.
    always_comb begin
        side_dly_d[0] = side_raw;
        for (int i = 1; i < int'(DL); i++) begin
            side_dly_d[i] = side_dly_q[i-1];
        end
    end

    // Output stage: colour gated by the delayed active flag, sync at configured polarity.
    always_comb begin
        tap  = side_dly_q[DL-1];
        hs_d = tap[S_HS] ? ~HS_POL : HS_POL;
        vs_d = tap[S_VS] ? ~VS_POL : VS_POL;
        de_d = tap[S_AC];
        fs_d = tap[S_FS];
        ls_d = tap[S_LS];
        r_d  = '0;
        g_d  = '0;
        b_d  = '0;
        if (tap[S_AC]) begin
            r_d = din[COLOR_W-1:0];
            g_d = din[2*COLOR_W-1:COLOR_W];
            b_d = din[3*COLOR_W-1:2*COLOR_W];
        end
    end

    // All state registers.
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            col_addr_q <= '0;
            row_addr_q <= '0;
            rd_en_q    <= 1'b0;
            side_dly_q <= '0;
            r_q        <= '0;
            g_q        <= '0;
            b_q        <= '0;
            hs_q       <= HS_POL;
            vs_q       <= VS_POL;
            de_q       <= 1'b0;
            fs_q       <= 1'b0;
            ls_q       <= 1'b0;
        end else begin
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            col_addr_q <= col_addr_d;
            row_addr_q <= row_addr_d;
            rd_en_q    <= rd_en_d;
            side_dly_q <= side_dly_d;
            r_q        <= r_d;
            g_q        <= g_d;
            b_q        <= b_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            de_q       <= de_d;
            fs_q       <= fs_d;
            ls_q       <= ls_d;
        end
    end

    assign col_addr    = col_addr_q;
    assign row_addr    = row_addr_q;
    assign rd_en       = rd_en_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign de          = de_q;
    assign r           = r_q;
    assign g           = g_q;
    assign b           = b_q;
    assign frame_start = fs_q;
    assign line_start  = ls_q;

endmodule

// File: tb/tb_vga_scaler_ctrl.sv
// Bench for vga_scaler_ctrl: three configurations on reduced timing, random RAM
// contents and random asynchronous resets, checked against a position-based model.
module tb_vga_scaler_ctrl;

    localparam int HA  = 32;
    localparam int HS  = 4;
    localparam int HB  = 3;
    localparam int HF  = 2;
    localparam int VA  = 16;
    localparam int VS  = 2;
    localparam int VB  = 3;
    localparam int VF  = 1;
    localparam int HT  = HA + HS + HB + HF;
    localparam int VT  = VA + VS + VB + VF;
    localparam int HA0 = HS + HB;
    localparam int VA0 = VS + VB;

    logic        clk;
    logic        clrn;
    logic [11:0] mem [0:1023];
    int          n;
    int          n_checks;
    int          n_errors;

    // Instance A: scale 8, 1-clock RAM, active-low syncs.
    logic [11:0] din_a, pa1;
    logic [1:0]  col_a;
    logic [0:0]  row_a;
    logic        rd_a, hs_a, vs_a, de_a, fs_a, ls_a;
    logic [3:0]  r_a, g_a, b_a;
    // Instance B: scale 4, combinational RAM.
    logic [11:0] din_b;
    logic [2:0]  col_b;
    logic [1:0]  row_b;
    logic        rd_b, hs_b, vs_b, de_b, fs_b, ls_b;
    logic [3:0]  r_b, g_b, b_b;
    // Instance C: no scaling, 3-clock RAM, active-high syncs.
    logic [11:0] din_c, pc1, pc2, pc3;
    logic [4:0]  col_c;
    logic [3:0]  row_c;
    logic        rd_c, hs_c, vs_c, de_c, fs_c, ls_c;
    logic [3:0]  r_c, g_c, b_c;

    vga_scaler_ctrl #(.H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HB), .H_FP(HF),
                      .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VB), .V_FP(VF),
                      .SCALE_LOG2(3), .RD_LAT(1), .COLOR_W(4),
                      .HS_POL(1'b0), .VS_POL(1'b0)) u_a (
        .vga_clk(clk), .clrn(clrn), .din(din_a), .col_addr(col_a), .row_addr(row_a),
        .rd_en(rd_a), .hs(hs_a), .vs(vs_a), .de(de_a), .r(r_a), .g(g_a), .b(b_a),
        .frame_start(fs_a), .line_start(ls_a));

    vga_scaler_ctrl #(.H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HB), .H_FP(HF),
                      .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VB), .V_FP(VF),
                      .SCALE_LOG2(2), .RD_LAT(0), .COLOR_W(4),
                      .HS_POL(1'b0), .VS_POL(1'b0)) u_b (
        .vga_clk(clk), .clrn(clrn), .din(din_b), .col_addr(col_b), .row_addr(row_b),
        .rd_en(rd_b), .hs(hs_b), .vs(vs_b), .de(de_b), .r(r_b), .g(g_b), .b(b_b),
        .frame_start(fs_b), .line_start(ls_b));

    vga_scaler_ctrl #(.H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HB), .H_FP(HF),
                      .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VB), .V_FP(VF),
                      .SCALE_LOG2(0), .RD_LAT(3), .COLOR_W(4),
                      .HS_POL(1'b1), .VS_POL(1'b1)) u_c (
        .vga_clk(clk), .clrn(clrn), .din(din_c), .col_addr(col_c), .row_addr(row_c),
        .rd_en(rd_c), .hs(hs_c), .vs(vs_c), .de(de_c), .r(r_c), .g(g_c), .b(b_c),
        .frame_start(fs_c), .line_start(ls_c));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM models with the latency each instance expects; texel (row,col) at row*64+col.
    always @(posedge clk) begin
        pa1 <= mem[32'(row_a) * 64 + 32'(col_a)];
        pc1 <= mem[32'(row_c) * 64 + 32'(col_c)];
        pc2 <= pc1;
        pc3 <= pc2;
    end
    assign din_a = pa1;
    assign din_c = pc3;
    always_comb din_b = mem[32'(row_b) * 64 + 32'(col_b)];

    // Clock edges seen since reset release.
    always @(posedge clk or negedge clrn) begin
        if (!clrn) n <= 0;
        else       n <= n + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected outputs from the raster position that is RD_LAT+2 (or 1 for addresses) edges old.
    task automatic check_inst(input string nm, input int s, input int lat, input int hp, input int vp,
                              input int hs, input int vs, input int de, input int fs, input int ls,
                              input int rgb, input int rd, input int col, input int row);
        int p, h, v, p1, h1, v1, e_de, e_act1, e_rgb;
        p = n - (lat + 2);
        if (p < 0) p = 0;
        h = p % HT;
        v = (p / HT) % VT;
        e_de  = int'(h >= HA0 && h < HA0 + HA && v >= VA0 && v < VA0 + VA);
        e_rgb = e_de ? int'(mem[((v - VA0) >> s) * 64 + ((h - HA0) >> s)]) : 0;
        check({nm, ".hs"}, hs, (h < HS) ? hp : 1 - hp);
        check({nm, ".vs"}, vs, (v < VS) ? vp : 1 - vp);
        check({nm, ".de"}, de, e_de);
        check({nm, ".frame_start"}, fs, int'(h == HA0 && v == VA0));
        check({nm, ".line_start"}, ls, int'(h == HA0 && v >= VA0 && v < VA0 + VA));
        check({nm, ".rgb"}, rgb, e_rgb);
        p1 = n - 1;
        if (p1 < 0) p1 = 0;
        h1 = p1 % HT;
        v1 = (p1 / HT) % VT;
        e_act1 = int'(h1 >= HA0 && h1 < HA0 + HA && v1 >= VA0 && v1 < VA0 + VA);
        check({nm, ".rd_en"}, rd, e_act1);
        check({nm, ".col_addr"}, col, e_act1 ? ((h1 - HA0) >> s) : 0);
        check({nm, ".row_addr"}, row, e_act1 ? ((v1 - VA0) >> s) : 0);
    endtask

    task automatic check_all();
        check_inst("a", 3, 1, 0, 0, int'(hs_a), int'(vs_a), int'(de_a), int'(fs_a), int'(ls_a),
                   int'({b_a, g_a, r_a}), int'(rd_a), int'(col_a), int'(row_a));
        check_inst("b", 2, 0, 0, 0, int'(hs_b), int'(vs_b), int'(de_b), int'(fs_b), int'(ls_b),
                   int'({b_b, g_b, r_b}), int'(rd_b), int'(col_b), int'(row_b));
        check_inst("c", 0, 3, 1, 1, int'(hs_c), int'(vs_c), int'(de_c), int'(fs_c), int'(ls_c),
                   int'({b_c, g_c, r_c}), int'(rd_c), int'(col_c), int'(row_c));
    endtask

    task automatic fill_mem(input bit ones);
        for (int i = 0; i < 1024; i++) mem[i] = ones ? 12'hfff : 12'($urandom);
    endtask

    initial begin
        int lat_v[3];
        int maxc[3];
        int maxr[3];
        int fsv[3];
        int seen[3];
        int de_cnt, hs_cnt, have_prev, len;
        n_checks = 0;
        n_errors = 0;
        lat_v = '{1, 0, 3};
        maxc  = '{0, 0, 0};
        maxr  = '{0, 0, 0};
        clrn  = 1'b0;
        fill_mem(1'b0);
        repeat (3) begin
            @(negedge clk);
            check_all();
        end
        for (int seg = 0; seg < 4; seg++) begin
            #1 clrn = 1'b1;
            seen      = '{0, 0, 0};
            de_cnt    = 0;
            hs_cnt    = 0;
            have_prev = 0;
            len = $urandom_range(2 * HT * VT + 300, 3 * HT * VT);
            for (int i = 0; i < len; i++) begin
                @(negedge clk);
                check_all();
                fsv = '{int'(fs_a), int'(fs_b), int'(fs_c)};
                for (int k = 0; k < 3; k++) begin
                    if (seen[k] == 0 && fsv[k] == 1) begin
                        check("first_frame_start_latency", n, VA0 * HT + HA0 + lat_v[k] + 2);
                        seen[k] = 1;
                    end
                end
                if (rd_a && int'(col_a) > maxc[0]) maxc[0] = int'(col_a);
                if (rd_a && int'(row_a) > maxr[0]) maxr[0] = int'(row_a);
                if (rd_b && int'(col_b) > maxc[1]) maxc[1] = int'(col_b);
                if (rd_b && int'(row_b) > maxr[1]) maxr[1] = int'(row_b);
                if (rd_c && int'(col_c) > maxc[2]) maxc[2] = int'(col_c);
                if (rd_c && int'(row_c) > maxr[2]) maxr[2] = int'(row_c);
                if (fs_a) begin
                    if (have_prev == 1) begin
                        check("a.de_clocks_per_frame", de_cnt, HA * VA);
                        check("a.hs_low_clocks_per_frame", hs_cnt, HS * VT);
                    end
                    have_prev = 1;
                    de_cnt    = 0;
                    hs_cnt    = 0;
                end
                if (have_prev == 1) begin
                    de_cnt += int'(de_a);
                    hs_cnt += int'(!hs_a);
                end
            end
            for (int k = 0; k < 3; k++) check("frame_start_seen", seen[k], 1);
            // Asynchronous reset somewhere mid-frame, checked before the next edge.
            @(posedge clk);
            #($urandom_range(1, 3)) clrn = 1'b0;
            #1;
            check_all();
            fill_mem(seg == 1);
            repeat ($urandom_range(2, 5)) begin
                @(negedge clk);
                check_all();
            end
        end
        check("a.max_col", maxc[0], 3);
        check("a.max_row", maxr[0], 1);
        check("b.max_col", maxc[1], 7);
        check("b.max_row", maxr[1], 3);
        check("c.max_col", maxc[2], 31);
        check("c.max_row", maxr[2], 15);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
